// File: rtl/oci_trace_pkg.sv
// Shared definitions for the OCI trace capture block: FSM state encoding,
// overflow counter width and the buffer entry width calculation.
package oci_trace_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int OVF_W = 8;

    // Entry layout is {timestamp (optional), count, word}.
    function automatic int entry_width(input int data_w, input int cnt_w,
                                       input int ts_w, input bit ts_en);
        return data_w + cnt_w + (ts_en ? ts_w : 0);
    endfunction

endpackage

// File: rtl/oci_trace_ram.sv
// Trace storage: DEPTH x ENTRY_W, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module oci_trace_ram #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 34,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write port: store the entry at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_oci_trace_capture.sv
// Debug trace capture buffer. Captures qualified trace words into a circular
// buffer while the test runs (overwriting the oldest entry when full), then
// drains them to a ready/valid consumer once the test is ending.
// Optional feature macro: OCI_TRACE_TIMESTAMP_EN prefixes each entry with a
// free-running TS_W-bit cycle count.
module cpu_oci_trace_capture
    import oci_trace_pkg::*;
#(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = entry_width(DATA_W, CNT_W, TS_W, 1'b1),
`else
    localparam int ENTRY_W = entry_width(DATA_W, CNT_W, TS_W, 1'b0),
`endif
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]   dct_count,
    input  logic               dct_valid,
    input  logic               test_ending,
    input  logic               test_has_ended,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [LVL_W-1:0]   level,
    output logic [OVF_W-1:0]   ovf_cnt,
    output logic               done
);

    localparam int PTR_W = $clog2(DEPTH);

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] ram_rd;
    logic               wr_en;
    logic               pop;
    logic               full;

    assign full     = (level == LVL_W'(DEPTH));
    assign wr_en    = (state == CAPTURE) && dct_valid && (dct_count != '0);
    assign rd_valid = (state == DRAIN) && (level != '0);
    assign pop      = rd_valid && rd_ready;
    // Gated so the output reads as zero whenever nothing valid is presented,
    // including while reset is held.
    assign rd_data  = rd_valid ? ram_rd : '0;

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    // Free-running cycle counter; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign wr_entry = {ts, dct_count, dct_buffer};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    // Pointer, level and overflow bookkeeping; a write when full drops the oldest entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (full) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + OVF_W'(1);
                end
            end else begin
                level <= level + LVL_W'(1);
            end
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            level  <= level - LVL_W'(1);
        end
    end

    // Capture/drain/done sequencing; DONE is left only through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CAPTURE;
            done  <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (test_ending) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((level == '0) && test_has_ended) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= CAPTURE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    oci_trace_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd)
    );

endmodule

// File: doc/cpu_oci_trace_capture.md
CPU_OCI_TRACE_CAPTURE -- requirements
Module: cpu_oci_trace_capture

Interface
REQ-001 Parameter DATA_W, default 30: width of one debug-trace word.
REQ-002 Parameter CNT_W, default 4: width of the trace valid-count field.
REQ-003 Parameter DEPTH, default 16: number of buffer entries; power of two, 2..256.
REQ-004 Parameter TS_W, default 16: timestamp width; used only when OCI_TRACE_TIMESTAMP_EN is defined.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 dct_buffer  in  DATA_W  trace word presented by the debug core.
REQ-008 dct_count  in  CNT_W  number of valid items in dct_buffer; 0 means no content.
REQ-009 dct_valid  in  1  dct_buffer/dct_count qualify this cycle.
REQ-010 test_ending  in  1  level; the test is finishing, so stop capture.
REQ-011 test_has_ended  in  1  level; the test is complete.
REQ-012 rd_ready  in  1  the consumer accepts rd_data.
REQ-013 rd_valid  out  1  rd_data holds the oldest unread entry.
REQ-014 rd_data  out  ENTRY_W  {timestamp (option), dct_count, dct_buffer}; ENTRY_W = DATA_W+CNT_W (+TS_W).
REQ-015 level  out  log2(DEPTH)+1  current entry count.
REQ-016 ovf_cnt  out  8  overwritten-entry count, saturating.
REQ-017 done  out  1  drain complete and test ended.

Function
REQ-018 The block SHALL implement the states CAPTURE, DRAIN and DONE.
- CAPTURE is entered at reset.
- CAPTURE goes to DRAIN on the first clk edge with test_ending=1.
- DRAIN goes to DONE on the edge where level=0 and test_has_ended=1.
- DONE is exited only by reset.
REQ-019 In CAPTURE, a write SHALL occur when dct_valid=1 and dct_count!=0.
- The entry is written at the write pointer.
- level increments by 1.
- Visibility: the entry is visible in level one cycle after the write.
REQ-020 A cycle with dct_count=0, or with dct_valid=0, SHALL NOT write.
REQ-021 Write when full (level=DEPTH):
- the new entry SHALL overwrite the oldest entry;
- the read pointer advances by 1;
- level stays at DEPTH;
- ovf_cnt increments, saturating at 255.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 A qualifying write in the same cycle as the first test_ending=1 SHALL be captured.
REQ-024 No writes SHALL occur in DRAIN or DONE.
REQ-025 rd_valid SHALL be 1 only in DRAIN with level!=0.
- rd_data = entry at the read pointer, combinational from storage.
REQ-026 A pop SHALL occur when rd_valid=1 and rd_ready=1.
- The read pointer advances and level decrements.
- The next entry is presented in the following cycle.
REQ-027 rd_data SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-028 A DRAIN entered with level=0 and test_has_ended=1 SHALL reach DONE one cycle later.
REQ-029 done SHALL be 1 exactly in DONE; rd_valid is 0 in DONE.

Reset
REQ-030 While reset_n=0, the block SHALL hold the following values, applied asynchronously:
- state=CAPTURE;
- both pointers, level and ovf_cnt = 0;
- rd_valid=0, done=0;
- rd_data = 0.
REQ-031 Reset asserted mid-drain SHALL discard all buffered entries; storage contents need not be cleared.
REQ-032 Release of reset_n SHALL take effect at the next clk edge; the first write is possible on that edge.

Configuration
REQ-033 Macro OCI_TRACE_TIMESTAMP_EN.
- Defined: a free-running TS_W-bit cycle counter (reset 0, wraps) SHALL be stored in the top TS_W bits of each entry at write time.
- Undefined: no counter exists, and ENTRY_W = DATA_W+CNT_W.

Structure
REQ-034 Shared package oci_trace_pkg SHALL hold:
- the state enumeration (CAPTURE=0, DRAIN=1, DONE=2);
- the ovf_cnt width constant;
- the ENTRY_W computation function.
REQ-035 Storage SHALL be a sub-module oci_trace_ram:
- DEPTH x ENTRY_W;
- one write port;
- one asynchronous read port.
Pointers, level and the state machine reside in the top level.

Verification
REQ-036 Basic write and drain: write 3 entries (count=1, words 0x1,0x2,0x3), then raise test_ending with rd_ready=1.
- rd_data words SHALL be 0x1,0x2,0x3 on consecutive cycles.
- level SHALL then be 0.
REQ-037 Overwrite: with DEPTH=16, write 20 entries numbered 0..19, then drain.
- The entries read SHALL be 4..19.
- ovf_cnt SHALL be 4.
REQ-038 Qualification: 5 cycles with dct_count=0 plus 2 cycles with dct_valid=0 -> level SHALL stay 0.
REQ-039 Backpressure: in DRAIN, hold rd_ready=0 for 4 cycles.
- rd_data SHALL be unchanged and rd_valid SHALL stay 1.
- Then set rd_ready=1: one pop per cycle.
REQ-040 Completion: set test_has_ended=1 after the drain empties.
- done SHALL be 1 on the next edge.
- Asserting reset_n=0 mid-drain -> level=0 and rd_valid=0 immediately.
REQ-041 Timestamp (with OCI_TRACE_TIMESTAMP_EN): writes on cycles 10 and 13 after reset release.
- Their timestamp fields SHALL differ by 3.
